// File: rtl/fu_issue_fifo.sv
// fu_issue_fifo: per-functional-unit input queue on the consumer side of the RS
// issue interface. Each cycle it captures the issued packets (slots 2,1,0; slot 2
// oldest) addressed to FU_SEL, buffers them in order, and presents one packet per
// cycle to the FU. fifo_stall is the near-full indication returned to the RS.
// Optional feature: define FU_FIFO_BYPASS_EN to let the oldest accepted packet
// drive fu_pkt in the same cycle when the queue is empty and the FU is ready.

package fu_issue_pkg;

  typedef enum logic [1:0] {
    ALU_1  = 2'd0,
    LS_1   = 2'd1,
    MULT_1 = 2'd2,
    BRANCH = 2'd3
  } fu_select_t;

  typedef struct packed {
    logic        valid;
    fu_select_t  dec_fu_unit_sel;
    logic [5:0]  rob_tag;
    logic [4:0]  dest_reg;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
  } rs_s_packet_t;

endpackage

module fu_issue_fifo
  import fu_issue_pkg::*;
#(
  parameter int         DEPTH        = 8,
  parameter int         STALL_THRESH = 3,
  parameter fu_select_t FU_SEL       = ALU_1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       squash,
  input  rs_s_packet_t [2:0]         rs_issue_pkts,
  input  logic                       fu_ready,
  output rs_s_packet_t               fu_pkt,
  output logic                       fu_pkt_valid,
  output logic                       fifo_stall,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Registered state
  rs_s_packet_t     mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;
  rs_s_packet_t     fu_pkt_q;

  // Next-state helpers
  rs_s_packet_t     ord_pkt [4];
  logic [1:0]       n_acc;
  logic             bypass;
  logic [1:0]       n_store;
  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] n_wr;
  logic [CNT_W-1:0] count_nxt;
  logic             pop;
  logic             overflow_set;
  logic [PTR_W-1:0] head_nxt;
  logic [PTR_W-1:0] tail_nxt;
  logic [DEPTH-1:0] wr_en;
  rs_s_packet_t     wr_data [DEPTH];
  rs_s_packet_t     head_pkt_nxt;
  rs_s_packet_t     fu_pkt_nxt;

  // Compact the accepted slots into oldest-first order (slot 2 is oldest).
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first;
    // any path that leaves one unassigned would infer a latch.
    n_acc = '0;
    for (int k = 0; k < 4; k++) ord_pkt[k] = '0;
    for (int i = 2; i >= 0; i--) begin
      if (rs_issue_pkts[i].valid && rs_issue_pkts[i].dec_fu_unit_sel == FU_SEL) begin
        ord_pkt[n_acc] = rs_issue_pkts[i];
        n_acc          = n_acc + 2'd1;
      end
    end
  end

`ifdef FU_FIFO_BYPASS_EN
  // Empty queue and a ready FU: the oldest accepted packet goes straight out.
  assign bypass = (count == '0) && !rst && !squash && fu_ready && (n_acc != 2'd0);
`else
  assign bypass = 1'b0;
`endif

  // Occupancy bookkeeping. Free space is taken from the registered count only,
  // so a same-cycle pop never makes room for a same-cycle push.
  assign n_store      = n_acc - {1'b0, bypass};
  assign free_slots   = CNT_W'(DEPTH) - count;
  assign n_wr         = (CNT_W'(n_store) > free_slots) ? free_slots : CNT_W'(n_store);
  assign overflow_set = !squash && (CNT_W'(n_store) > free_slots);
  assign pop          = (count != '0) && fu_ready;
  assign count_nxt    = count + n_wr - CNT_W'(pop);
  assign head_nxt     = head_ptr + PTR_W'(pop);
  assign tail_nxt     = tail_ptr + PTR_W'(n_wr);

  // Decode which storage entries are written this cycle and with what.
  always_comb begin
    wr_en = '0;
    for (int e = 0; e < DEPTH; e++) wr_data[e] = '0;
    for (int j = 0; j < 3; j++) begin
      if (!rst && !squash && (CNT_W'(j) < n_wr)) begin
        wr_en[tail_ptr + PTR_W'(j)]   = 1'b1;
        wr_data[tail_ptr + PTR_W'(j)] = ord_pkt[2'(j) + {1'b0, bypass}];
      end
    end
  end

  // Next head packet as seen after this cycle's writes (forwarding a packet
  // that lands directly in the head slot), or zero when the queue will be empty.
  always_comb begin
    head_pkt_nxt = wr_en[head_nxt] ? wr_data[head_nxt] : mem[head_nxt];
    fu_pkt_nxt   = (count_nxt != '0) ? head_pkt_nxt : '0;
  end

  // Pointer, count, head-register and sticky-error update.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      head_ptr     <= '0;
      tail_ptr     <= '0;
      count        <= '0;
      fu_pkt_q     <= '0;
      overflow_err <= 1'b0;
    end else if (squash) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      fu_pkt_q <= '0;
    end else begin
      head_ptr <= head_nxt;
      tail_ptr <= tail_nxt;
      count    <= count_nxt;
      fu_pkt_q <= fu_pkt_nxt;
      if (overflow_set) overflow_err <= 1'b1;
    end
  end

  // Entry storage: written in place, never cleared.
  always_ff @(posedge clk) begin
    // NOTE: the entry array has no reset; count and the pointers decide which
    // entries are live, so clearing it would only add a reset net to every bit.
    for (int e = 0; e < DEPTH; e++) begin
      if (wr_en[e]) mem[e] <= wr_data[e];
    end
  end

  assign fu_pkt       = bypass ? ord_pkt[0] : fu_pkt_q;
  assign fu_pkt_valid = bypass || (count != '0);
  assign fifo_stall   = free_slots < CNT_W'(STALL_THRESH);
  assign occupancy    = count;

endmodule

// File: tb/tb_fu_issue_fifo.sv
// Self-checking bench for fu_issue_fifo: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_fu_issue_fifo;
  import fu_issue_pkg::*;

  localparam int DEPTH  = 8;
  localparam int THRESH = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               squash;
  logic               fu_ready;
  rs_s_packet_t [2:0] rs_issue_pkts;
  rs_s_packet_t       fu_pkt;
  logic               fu_pkt_valid;
  logic               fifo_stall;
  logic [3:0]         occupancy;
  logic               overflow_err;

  int n_checks = 0;
  int n_fail   = 0;
  int next_tag = 0;

  rs_s_packet_t model_q[$];
  rs_s_packet_t acc_q[$];
  bit           model_ovf  = 1'b0;
  bit           model_live = 1'b0;

  always #5 clk = ~clk;

  fu_issue_fifo #(
    .DEPTH       (DEPTH),
    .STALL_THRESH(THRESH),
    .FU_SEL      (ALU_1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .squash       (squash),
    .rs_issue_pkts(rs_issue_pkts),
    .fu_ready     (fu_ready),
    .fu_pkt       (fu_pkt),
    .fu_pkt_valid (fu_pkt_valid),
    .fifo_stall   (fifo_stall),
    .occupancy    (occupancy),
    .overflow_err (overflow_err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic rs_s_packet_t mk_pkt(input logic v, input fu_select_t sel);
    rs_s_packet_t p;
    p.valid           = v;
    p.dec_fu_unit_sel = sel;
    p.rob_tag         = 6'(next_tag);
    p.dest_reg        = 5'($urandom);
    p.rs1_value       = $urandom;
    p.rs2_value       = $urandom;
    next_tag++;
    return p;
  endfunction

  // Accepted packets this cycle, oldest (slot 2) first.
  task automatic collect_acc();
    acc_q.delete();
    for (int i = 2; i >= 0; i--)
      if (rs_issue_pkts[i].valid && rs_issue_pkts[i].dec_fu_unit_sel == ALU_1)
        acc_q.push_back(rs_issue_pkts[i]);
  endtask

  task automatic check_outputs();
    rs_s_packet_t exp_pkt;
    logic         exp_valid;
    if (!model_live) return;
    exp_valid = (model_q.size() != 0);
    exp_pkt   = '0;
    if (exp_valid) exp_pkt = model_q[0];
`ifdef FU_FIFO_BYPASS_EN
    collect_acc();
    if (!exp_valid && !rst && !squash && fu_ready && acc_q.size() != 0) begin
      exp_valid = 1'b1;
      exp_pkt   = acc_q[0];
    end
`endif
    check("fu_pkt_valid", 128'(fu_pkt_valid), 128'(exp_valid));
    check("fu_pkt",       128'(fu_pkt),       128'(exp_pkt));
    check("occupancy",    128'(occupancy),    128'(model_q.size()));
    check("fifo_stall",   128'(fifo_stall),   128'((DEPTH - model_q.size()) < THRESH));
    check("overflow_err", 128'(overflow_err), 128'(model_ovf));
  endtask

  // Reference behaviour for one clock edge.
  task automatic model_step();
    int free_n;
    int take;
    bit do_pop;
    if (rst) begin
      model_q.delete();
      model_ovf  = 1'b0;
      model_live = 1'b1;
      return;
    end
    if (!model_live) return;
    if (squash) begin
      model_q.delete();
      return;
    end
    collect_acc();
    do_pop = (model_q.size() != 0) && fu_ready;
`ifdef FU_FIFO_BYPASS_EN
    if (model_q.size() == 0 && fu_ready && acc_q.size() != 0) void'(acc_q.pop_front());
`endif
    free_n = DEPTH - model_q.size();
    if (acc_q.size() > free_n) model_ovf = 1'b1;
    take = (acc_q.size() > free_n) ? free_n : acc_q.size();
    for (int k = 0; k < take; k++) model_q.push_back(acc_q[k]);
    if (do_pop) void'(model_q.pop_front());
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_slots();
    rs_issue_pkts = '0;
  endtask

  task automatic push3(input fu_select_t s2, input fu_select_t s1, input fu_select_t s0);
    rs_issue_pkts[2] = mk_pkt(1'b1, s2);
    rs_issue_pkts[1] = mk_pkt(1'b1, s1);
    rs_issue_pkts[0] = mk_pkt(1'b1, s0);
  endtask

  initial begin
    logic [5:0] tag_a;
    logic [5:0] tag_b;
    logic [5:0] tag_c;
    rst      = 1'b1;
    squash   = 1'b0;
    fu_ready = 1'b0;
    rs_issue_pkts = '0;

    // 1. Reset
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;
    check("reset_valid", 128'(fu_pkt_valid), 128'(0));
    check("reset_occ",   128'(occupancy),    128'(0));
    check("reset_stall", 128'(fifo_stall),   128'(0));
    check("reset_ovf",   128'(overflow_err), 128'(0));

    // 2. Three matching packets, then drain in order
    push3(ALU_1, ALU_1, ALU_1);
    tag_a = rs_issue_pkts[2].rob_tag;
    tag_b = rs_issue_pkts[1].rob_tag;
    tag_c = rs_issue_pkts[0].rob_tag;
    cycle();
    clear_slots();
    fu_ready = 1'b1;
    check("occ_after_push3", 128'(occupancy), 128'(3));
    check("order_a", 128'(fu_pkt.rob_tag), 128'(tag_a));
    cycle();
    check("order_b", 128'(fu_pkt.rob_tag), 128'(tag_b));
    cycle();
    check("order_c", 128'(fu_pkt.rob_tag), 128'(tag_c));
    cycle();
    check("occ_drained", 128'(occupancy), 128'(0));

    // 3. Mixed FU types: slots 2 and 0 match
    fu_ready = 1'b0;
    push3(ALU_1, LS_1, ALU_1);
    tag_a = rs_issue_pkts[2].rob_tag;
    tag_c = rs_issue_pkts[0].rob_tag;
    cycle();
    clear_slots();
    check("occ_mixed", 128'(occupancy), 128'(2));
    fu_ready = 1'b1;
    check("mixed_first", 128'(fu_pkt.rob_tag), 128'(tag_a));
    cycle();
    check("mixed_second", 128'(fu_pkt.rob_tag), 128'(tag_c));
    cycle();

    // 4. Fill to 6 -> stall; one pop -> 5, stall clears
    fu_ready = 1'b0;
    push3(ALU_1, ALU_1, ALU_1);
    cycle();
    push3(ALU_1, ALU_1, ALU_1);
    cycle();
    clear_slots();
    check("occ_six",   128'(occupancy),  128'(6));
    check("stall_six", 128'(fifo_stall), 128'(1));
    fu_ready = 1'b1;
    cycle();
    fu_ready = 1'b0;
    check("occ_five",   128'(occupancy),  128'(5));
    check("stall_five", 128'(fifo_stall), 128'(0));

    // 5. Up to 7, then push 3 -> overflow
    rs_issue_pkts[2] = mk_pkt(1'b1, ALU_1);
    rs_issue_pkts[1] = mk_pkt(1'b1, ALU_1);
    cycle();
    check("occ_seven", 128'(occupancy),    128'(7));
    check("ovf_clear", 128'(overflow_err), 128'(0));
    push3(ALU_1, ALU_1, ALU_1);
    cycle();
    clear_slots();
    check("occ_full", 128'(occupancy),    128'(8));
    check("ovf_set",  128'(overflow_err), 128'(1));
    fu_ready = 1'b1;
    for (int k = 0; k < 9; k++) cycle();
    check("ovf_sticky", 128'(overflow_err), 128'(1));
    check("occ_empty",  128'(occupancy),    128'(0));

    // 6. Squash at count 4 with a same-cycle push
    fu_ready = 1'b0;
    push3(ALU_1, ALU_1, ALU_1);
    cycle();
    clear_slots();
    rs_issue_pkts[2] = mk_pkt(1'b1, ALU_1);
    cycle();
    check("occ_four", 128'(occupancy), 128'(4));
    rs_issue_pkts[2] = mk_pkt(1'b1, ALU_1);
    rs_issue_pkts[1] = mk_pkt(1'b1, ALU_1);
    squash   = 1'b1;
    fu_ready = 1'b1;
    cycle();
    squash = 1'b0;
    clear_slots();
    check("squash_occ",   128'(occupancy),    128'(0));
    check("squash_valid", 128'(fu_pkt_valid), 128'(0));
    check("squash_ovf",   128'(overflow_err), 128'(1));
    for (int k = 0; k < 3; k++) cycle();

`ifdef FU_FIFO_BYPASS_EN
    // Bypass: empty, ready, one push -> same-cycle output, nothing stored
    rs_issue_pkts[2] = mk_pkt(1'b1, ALU_1);
    tag_a = rs_issue_pkts[2].rob_tag;
    #1;
    check("bypass_valid", 128'(fu_pkt_valid),   128'(1));
    check("bypass_pkt",   128'(fu_pkt.rob_tag), 128'(tag_a));
    cycle();
    clear_slots();
    check("bypass_occ", 128'(occupancy), 128'(0));
    cycle();
`endif

    // Reset clears the sticky error
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_clears_ovf", 128'(overflow_err), 128'(0));

    // Random traffic with alternating light and heavy phases
    for (int n = 0; n < 3000; n++) begin
      bit heavy;
      heavy    = ((n / 100) % 2) == 1;
      rst      = ($urandom_range(0, 299) == 0);
      squash   = ($urandom_range(0, 49) == 0);
      fu_ready = heavy ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 3; i++) begin
        fu_select_t sel;
        if (heavy) sel = ($urandom_range(0, 3) != 0) ? ALU_1 : fu_select_t'($urandom_range(1, 3));
        else       sel = fu_select_t'($urandom_range(0, 3));
        rs_issue_pkts[i] = mk_pkt(1'($urandom_range(0, 1)), sel);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
